// File: rtl/l2_read_responder.sv
// L2-side read responder: queues L1 line-miss addresses, waits a fixed latency, then
// streams each line from a synchronous RAM as a burst of bus-width beats, critical beat first.
module l2_read_responder #(
  parameter int B           = 9,
  parameter int W           = 7,
  parameter int L2_DELAY_RD = 7,
  parameter int RAM_AW      = 14,
  parameter int Q           = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [29:0]           ADDR_IN,
  input  logic                  ADDR_IN_VALID,
  output logic                  ADDR_IN_READY,
  output logic [2**W-1:0]       DATA_OUT,
  output logic                  DATA_OUT_VALID,
  input  logic                  DATA_OUT_READY,
  output logic                  MEM_RD_EN,
  output logic [RAM_AW-W+4:0]   MEM_RD_ADDR,
  input  logic [2**W-1:0]       MEM_RD_DATA
);

  localparam int IW        = B - W;
  localparam int BURST_LEN = 2 ** IW;
  localparam int HW        = RAM_AW - W + 5;
  localparam int DEPTH     = 2 ** Q;
  localparam int WAIT_LOAD = L2_DELAY_RD - 3;
  localparam int CW        = $clog2(L2_DELAY_RD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   beat_idx;
  logic [IW-1:0]   beats;
  logic            dvalid;
  logic            ready_en;

  logic [HW-1:0]   fifo [DEPTH];
  logic [Q-1:0]    wr_ptr;
  logic [Q-1:0]    rd_ptr;
  logic [Q:0]      count;

  logic            full;
  logic            push;
  logic            pop;
  logic            last_issue;
  logic [HW-1:0]   head;
  logic            unused_addr_bits;

  // Only the bus-word address within the RAM is kept; higher bits alias.
  assign unused_addr_bits = ^{ADDR_IN[29:RAM_AW], ADDR_IN[W-6:0]};

  assign full          = (count == (Q+1)'(DEPTH));
  assign ADDR_IN_READY = ready_en & ~full & DATA_OUT_READY & ~RST;
  assign push          = ADDR_IN_VALID & ADDR_IN_READY;
  assign head          = fifo[rd_ptr];
  assign last_issue    = (state == S_BURST) && (beats == IW'(BURST_LEN - 1));
  assign MEM_RD_EN     = (state == S_BURST) & DATA_OUT_READY & ~RST;
  assign pop           = MEM_RD_EN & last_issue;
  assign MEM_RD_ADDR   = {head[HW-1:IW], beat_idx};
  assign DATA_OUT       = MEM_RD_DATA;
  assign DATA_OUT_VALID = dvalid;

  always_ff @(posedge CLK) begin
    if (push) fifo[wr_ptr] <= ADDR_IN[RAM_AW-1:W-5];
  end

  // ready_en keeps READY low until the first edge sampled with reset released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      beat_idx <= '0;
      beats    <= '0;
      dvalid   <= 1'b0;
    end else if (DATA_OUT_READY) begin
      dvalid <= MEM_RD_EN;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            if (WAIT_LOAD == 0) begin
              state    <= S_BURST;
              beat_idx <= head[IW-1:0];
              beats    <= '0;
            end else begin
              state <= S_WAIT;
              cnt   <= CW'(WAIT_LOAD);
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= S_BURST;
            beat_idx <= head[IW-1:0];
            beats    <= '0;
          end
        end
        S_BURST: begin
          beat_idx <= beat_idx + 1'b1;
          beats    <= beats + 1'b1;
          if (last_issue) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_read_responder.sv
// Bench for l2_read_responder: behavioural timing model of request acceptance and bursts,
// a RAM model answering the DUT, directed latency/order/stall/reset cases and a random run.
module tb_l2_read_responder;

  localparam int D  = 7;
  localparam int NB = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [29:0]   ADDR_IN = '0;
  logic          ADDR_IN_VALID = 1'b0;
  logic          ADDR_IN_READY;
  logic [127:0]  DATA_OUT;
  logic          DATA_OUT_VALID;
  logic          DATA_OUT_READY = 1'b1;
  logic          MEM_RD_EN;
  logic [11:0]   MEM_RD_ADDR;
  logic [127:0]  MEM_RD_DATA = '0;

  always #5 CLK = ~CLK;

  l2_read_responder dut (
    .CLK(CLK),
    .RST(RST),
    .ADDR_IN(ADDR_IN),
    .ADDR_IN_VALID(ADDR_IN_VALID),
    .ADDR_IN_READY(ADDR_IN_READY),
    .DATA_OUT(DATA_OUT),
    .DATA_OUT_VALID(DATA_OUT_VALID),
    .DATA_OUT_READY(DATA_OUT_READY),
    .MEM_RD_EN(MEM_RD_EN),
    .MEM_RD_ADDR(MEM_RD_ADDR),
    .MEM_RD_DATA(MEM_RD_DATA)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model time advances only on edges that are neither stalled nor reset.
  int           k = 0;
  bit           rst_done = 0;
  int           last_end = -1000;
  int           m_accept[$];
  int           m_start[$];
  logic [29:0]  m_addr[$];
  logic [11:0]  issued[$];

  int  cyc = 0, first_v = -1, last_v = -1, beats_taken = 0, gap_run = 0;
  bit  seen_valid = 0;
  int  gaps[$];

  function automatic logic [127:0] ram_word(input logic [11:0] a);
    logic [31:0] h;
    h = {20'h0, a} * 32'h9E3779B1 + 32'h01234567;
    return {h, ~h, h ^ 32'hA5A5A5A5, 20'hABCDE, a};
  endfunction

  function automatic logic [11:0] beat_addr(input logic [29:0] a, input int j);
    logic [1:0] idx;
    idx = a[3:2] + 2'(j);
    return {a[13:4], idx};
  endfunction

  function automatic int occupancy();
    int n = 0;
    foreach (m_start[i])
      if (m_accept[i] <= k && k < m_start[i] + NB - 1) n++;
    return n;
  endfunction

  function automatic bit exp_ready_now();
    return rst_done && !RST && DATA_OUT_READY && (occupancy() < 2**2);
  endfunction

  always @(posedge CLK) MEM_RD_DATA <= MEM_RD_EN ? ram_word(MEM_RD_ADDR) : MEM_RD_DATA;

  always @(posedge CLK) begin
    int s;
    bit acc;
    if (MEM_RD_EN) issued.push_back(MEM_RD_ADDR);
    if (RST) begin
      m_accept.delete();
      m_start.delete();
      m_addr.delete();
      rst_done = 0;
      last_end = -1000;
    end else begin
      acc = ADDR_IN_VALID && exp_ready_now();
      rst_done = 1;
      if (DATA_OUT_READY) begin
        k++;
        if (acc) begin
          s = ((k > last_end) ? k : last_end) + D - 1;
          m_accept.push_back(k);
          m_start.push_back(s);
          m_addr.push_back(ADDR_IN);
          last_end = s + NB - 1;
        end
      end
      while (m_start.size() > 0 && m_start[0] + NB - 1 < k) begin
        void'(m_accept.pop_front());
        void'(m_start.pop_front());
        void'(m_addr.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearMon();
    cyc = 0; first_v = -1; last_v = -1; beats_taken = 0; gap_run = 0;
    seen_valid = 0;
    gaps.delete();
  endtask

  task automatic checkOutput();
    bit           exp_valid = 0;
    bit           exp_en = 0;
    logic [127:0] exp_data = '0;
    foreach (m_start[i]) begin
      if (k >= m_start[i] && k <= m_start[i] + NB - 1) begin
        exp_valid = 1;
        exp_data  = ram_word(beat_addr(m_addr[i], k - m_start[i]));
      end
      if (k >= m_start[i] - 1 && k <= m_start[i] + NB - 2) exp_en = 1;
    end
    exp_en = exp_en && DATA_OUT_READY && !RST;
    check("addr_in_ready", ADDR_IN_READY, exp_ready_now());
    check("mem_rd_en", MEM_RD_EN, exp_en);
    check("data_out_valid", DATA_OUT_VALID, exp_valid);
    if (exp_valid) check("data_out", DATA_OUT, exp_data);
    if (DATA_OUT_VALID) begin
      if (first_v < 0) first_v = cyc;
      if (seen_valid && gap_run > 0) gaps.push_back(gap_run);
      gap_run = 0;
      seen_valid = 1;
      last_v = cyc;
      if (DATA_OUT_READY) beats_taken++;
    end else if (seen_valid) begin
      gap_run++;
    end
    cyc++;
  endtask

  always @(negedge CLK) begin
    #2;
    if (chk_en) checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic [29:0] a, input logic r,
                               input logic rs);
    @(negedge CLK);
    ADDR_IN_VALID  = v;
    ADDR_IN        = a;
    DATA_OUT_READY = r;
    RST            = rs;
  endtask

  task automatic directedLine(input string tag, input logic [29:0] a,
                              input logic [11:0] e0, input logic [11:0] e1,
                              input logic [11:0] e2, input logic [11:0] e3);
    int first = -1;
    int nv = 0;
    logic [11:0] exp_seq [4];
    exp_seq[0] = e0; exp_seq[1] = e1; exp_seq[2] = e2; exp_seq[3] = e3;
    issued.delete();
    applyStimulus(1'b1, a, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
      #3;
      if (DATA_OUT_VALID) begin
        if (first < 0) first = i;
        nv++;
      end
    end
    check({tag, "_first_valid_edge"}, 128'(first), 128'(6));
    check({tag, "_valid_beats"}, 128'(nv), 128'(4));
    check({tag, "_issue_count"}, 128'(issued.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      check({tag, "_ram_word"}, (i < issued.size()) ? issued[i] : 12'hFFF, exp_seq[i]);
  endtask

  initial begin
    logic [29:0] t3_addr [5];
    int n, first_low;
    bit found;

    @(posedge CLK);
    chk_en = 1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 30'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
    #3 check("ready_low_after_reset", ADDR_IN_READY, 1'b0);
    check("valid_low_after_reset", DATA_OUT_VALID, 1'b0);
    check("mem_en_low_after_reset", MEM_RD_EN, 1'b0);
    applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
    #3 check("ready_rises", ADDR_IN_READY, 1'b1);

    $display("[TB] T1/T2 latency and critical-beat order");
    directedLine("t1", 30'h100, 12'h040, 12'h041, 12'h042, 12'h043);
    directedLine("t2", 30'h10A, 12'h042, 12'h043, 12'h040, 12'h041);

    $display("[TB] T3 back-to-back requests");
    t3_addr[0] = 30'h0000_0204; t3_addr[1] = 30'h2000_0338; t3_addr[2] = 30'h0000_3FFC;
    t3_addr[3] = 30'h1555_5111; t3_addr[4] = 30'h0000_0020;
    clearMon();
    n = 0; first_low = -1;
    for (int c = 0; c < 30 && n < 5; c++) begin
      applyStimulus(1'b1, t3_addr[n], 1'b1, 1'b0);
      #3;
      if (ADDR_IN_READY) n++;
      else if (first_low < 0) first_low = n;
    end
    check("t3_accepts_before_full", 128'(first_low), 128'(4));
    check("t3_all_accepted", 128'(n), 128'(5));
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
    check("t3_beats", 128'(beats_taken), 128'(20));
    check("t3_gap_count", 128'(gaps.size()), 128'(4));
    foreach (gaps[i]) check("t3_gap_len", 128'(gaps[i]), 128'(5));

    $display("[TB] T4 stall on second beat");
    clearMon();
    applyStimulus(1'b1, 30'h0000_0250, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
      #3;
      if (DATA_OUT_VALID) found = 1;
    end
    check("t4_first_beat_seen", found, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 30'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
    check("t4_beats", 128'(beats_taken), 128'(4));
    check("t4_span", 128'(last_v - first_v), 128'(6));

    $display("[TB] T5 reset mid-burst");
    clearMon();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 30'h0000_0400 + 30'(i * 16), 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
      #3;
      if (beats_taken == 2) found = 1;
    end
    check("t5_two_beats_seen", found, 1'b1);
    applyStimulus(1'b0, 30'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
    clearMon();
    #3 check("t5_valid_after_reset", DATA_OUT_VALID, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
    check("t5_no_beats", 128'(beats_taken), 128'(0));
    clearMon();
    applyStimulus(1'b1, 30'h0000_0123, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);
    check("t5_new_request_beats", 128'(beats_taken), 128'(4));

    $display("[TB] T6 random traffic");
    for (int i = 0; i < 1000; i++)
      applyStimulus(1'($urandom_range(0, 1)), 30'($urandom),
                    1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 299) == 0));
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 30'h0, 1'b1, 1'b0);

    @(negedge CLK);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
